gmem_wb_buffer: RTL

GMEM_WB_BUFFER -- requirements
Module: gmem_wb_buffer

---
 rtl/fcpu_pkg.sv | 10 +
 rtl/gmem_wb_buffer_if.sv | 47 ++++
 rtl/gmem_wb_buffer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fcpu_pkg.sv
// Shared FCPU geometry parameters for the global-memory write-back path.
// BEATS = 2**BURST_WORDS_W / CACHE_N_BANKS = 4 and BW/8 = SW = 16 with these values.
package fcpu_pkg;
   localparam int M             = 4;
   localparam int L             = 6;
   localparam int N             = 2;
   localparam int DATA_W        = 32;
   localparam int CACHE_N_BANKS = 4;
   localparam int BURST_WORDS_W = 4;
endpackage

// File: rtl/gmem_wb_buffer_if.sv
// Signal bundle between the write-back buffer, the cache read port and the AXI-style memory port.
// The slave modport is the buffer itself; master is the surrounding environment.
interface gmem_wb_buffer_if #(
   parameter int GMEM_ADDR_W = 32
);
   import fcpu_pkg::*;

   localparam int BW = CACHE_N_BANKS * DATA_W;
   localparam int SW = DATA_W / 8 * (2 ** N);

   logic                   wb_req;
   logic [M+L-1:0]         wb_line_addr;
   logic [GMEM_ADDR_W-1:0] wb_gmem_addr;
   logic                   wb_ack;
   logic                   ticket_rqst_rd;
   logic                   ticket_ack_rd_fifo;
   logic [M+L-1:0]         rd_fifo_rqst_addr;
   logic                   rd_fifo_din_v;
   logic [BW-1:0]          dob;
   logic [SW-1:0]          be_rdData;
   logic [GMEM_ADDR_W-1:0] awaddr;
   logic [7:0]             awlen;
   logic                   awvalid;
   logic                   awready;
   logic [BW-1:0]          wdata;
   logic [SW-1:0]          wstrb;
   logic                   wlast;
   logic                   wvalid;
   logic                   wready;
   logic                   bvalid;
   logic                   bready;
   logic                   busy;

   modport slave (
      input  wb_req, wb_line_addr, wb_gmem_addr, ticket_ack_rd_fifo, rd_fifo_din_v, dob, be_rdData,
             awready, wready, bvalid,
      output wb_ack, ticket_rqst_rd, rd_fifo_rqst_addr, awaddr, awlen, awvalid, wdata, wstrb, wlast,
             wvalid, bready, busy
   );

   modport master (
      output wb_req, wb_line_addr, wb_gmem_addr, ticket_ack_rd_fifo, rd_fifo_din_v, dob, be_rdData,
             awready, wready, bvalid,
      input  wb_ack, ticket_rqst_rd, rd_fifo_rqst_addr, awaddr, awlen, awvalid, wdata, wstrb, wlast,
             wvalid, bready, busy
   );
endinterface

// File: rtl/gmem_wb_buffer.sv
// Cache-line write-back buffer: fetches a line from cache port b into a reserved FIFO and
// streams it to global memory as one AW burst plus BEATS W beats, tracking B responses.
module gmem_wb_buffer
   import fcpu_pkg::*;
#(
   parameter int FIFO_DEPTH  = 2 * ((2 ** BURST_WORDS_W) / CACHE_N_BANKS),
   parameter int GMEM_ADDR_W = 32
) (
   input logic             clk,
   input logic             nrst,
   gmem_wb_buffer_if.slave bus
);
   localparam int BEATS = (2 ** BURST_WORDS_W) / CACHE_N_BANKS;
   localparam int BW    = CACHE_N_BANKS * DATA_W;
   localparam int SW    = DATA_W / 8 * (2 ** N);
   localparam int LA_W  = M + L;
   localparam int EW    = BW + SW;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int BC_W  = $clog2(BEATS + 1);
   localparam int OC_W  = 8;

   if (SW != BW / 8) begin : g_sw_chk
      $error("gmem_wb_buffer: strobe width SW does not match BW/8");
   end
   if (((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (FIFO_DEPTH < BEATS)) begin : g_depth_chk
      $error("gmem_wb_buffer: FIFO_DEPTH must be a power of 2 and at least BEATS");
   end

   typedef enum logic [1:0] {IDLE = 2'd0, TICKET = 2'd1, CAPTURE = 2'd2} state_t;

   state_t                 state_q, state_d;
   logic                   wb_ack_q, wb_ack_d;
   logic                   ticket_q, ticket_d;
   logic [LA_W-1:0]        line_addr_q, line_addr_d;
   logic [GMEM_ADDR_W-1:0] awaddr_q, awaddr_d;
   logic                   aw_pend_q, aw_pend_d;
   logic [CNT_W-1:0]       res_q, res_d;
   logic [BC_W-1:0]        cap_cnt_q, cap_cnt_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [BC_W-1:0]        w_cnt_q, w_cnt_d;
   logic [OC_W-1:0]        oc_q, oc_d;
   logic                   wvalid_q, wvalid_d;
   logic                   wlast_q, wlast_d;
   logic [BW-1:0]          wdata_q, wdata_d;
   logic [SW-1:0]          wstrb_q, wstrb_d;
   logic                   busy_q, busy_d;
   logic [EW-1:0]          mem_q [FIFO_DEPTH];
   logic [EW-1:0]          mem_d [FIFO_DEPTH];

   logic [CNT_W-1:0]       free_s;
   logic                   aw_hs_s;
   logic                   fifo_wr_s;
   logic                   pop_s;
   logic [EW-1:0]          head_s;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
   endfunction

   // Job sequencing: accept, ticket, capture; space is reserved up front so capture never stalls.
   always_comb begin
      state_d     = state_q;
      wb_ack_d    = 1'b0;
      ticket_d    = ticket_q;
      line_addr_d = line_addr_q;
      awaddr_d    = awaddr_q;
      res_d       = res_q;
      cap_cnt_d   = cap_cnt_q;
      fifo_wr_s   = 1'b0;
      free_s      = CNT_W'(FIFO_DEPTH) - count_q - res_q;
      aw_hs_s     = aw_pend_q & bus.awready;
      aw_pend_d   = aw_pend_q & ~aw_hs_s;
      case (state_q)
         IDLE: begin
            if (bus.wb_req && (free_s >= CNT_W'(BEATS))) begin
               wb_ack_d    = 1'b1;
               line_addr_d = bus.wb_line_addr;
               awaddr_d    = bus.wb_gmem_addr;
               res_d       = res_q + CNT_W'(BEATS);
               cap_cnt_d   = BC_W'(0);
               aw_pend_d   = 1'b1;
               state_d     = TICKET;
            end else begin
               state_d = IDLE;
            end
         end
         TICKET: begin
            if (ticket_q && bus.ticket_ack_rd_fifo) begin
               ticket_d = 1'b0;
               state_d  = CAPTURE;
            end else begin
               ticket_d = 1'b1;
            end
         end
         CAPTURE: begin
            if (bus.rd_fifo_din_v && (cap_cnt_q < BC_W'(BEATS))) begin
               fifo_wr_s = 1'b1;
               res_d     = res_q - CNT_W'(1);
               cap_cnt_d = cap_cnt_q + BC_W'(1);
            end else begin
               fifo_wr_s = 1'b0;
            end
            if ((cap_cnt_d == BC_W'(BEATS)) && !aw_pend_d) begin
               state_d = IDLE;
            end else begin
               state_d = CAPTURE;
            end
         end
         default: begin
            state_d  = IDLE;
            ticket_d = 1'b0;
         end
      endcase
   end

   // FIFO, W output stage and B tracking; head comes from mem_d so a write into an empty FIFO shows next cycle.
   always_comb begin
      pop_s    = wvalid_q & bus.wready;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      w_cnt_d  = w_cnt_q;
      if (fifo_wr_s) begin
         mem_d[wr_ptr_q] = {bus.dob, bus.be_rdData};
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
         w_cnt_d  = (w_cnt_q == BC_W'(BEATS - 1)) ? BC_W'(0) : w_cnt_q + BC_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({fifo_wr_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      head_s   = mem_d[rd_ptr_d];
      wvalid_d = (count_d != CNT_W'(0));
      if (wvalid_d) begin
         wdata_d = head_s[EW-1:SW];
         wstrb_d = head_s[SW-1:0];
      end else begin
         wdata_d = wdata_q;
         wstrb_d = wstrb_q;
      end
      wlast_d = wvalid_d && (w_cnt_d == BC_W'(BEATS - 1));
      if (aw_hs_s && !bus.bvalid) begin
         oc_d = oc_q + OC_W'(1);
      end else if (!aw_hs_s && bus.bvalid && (oc_q != OC_W'(0))) begin
         oc_d = oc_q - OC_W'(1);
      end else begin
         oc_d = oc_q;
      end
      busy_d = (state_d != IDLE) | aw_pend_d | wvalid_d | (oc_d != OC_W'(0));
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q     <= IDLE;
         wb_ack_q    <= 1'b0;
         ticket_q    <= 1'b0;
         line_addr_q <= LA_W'(0);
         awaddr_q    <= GMEM_ADDR_W'(0);
         aw_pend_q   <= 1'b0;
         res_q       <= CNT_W'(0);
         cap_cnt_q   <= BC_W'(0);
         count_q     <= CNT_W'(0);
         wr_ptr_q    <= PTR_W'(0);
         rd_ptr_q    <= PTR_W'(0);
         w_cnt_q     <= BC_W'(0);
         oc_q        <= OC_W'(0);
         wvalid_q    <= 1'b0;
         wlast_q     <= 1'b0;
         wdata_q     <= BW'(0);
         wstrb_q     <= SW'(0);
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wb_ack_q    <= wb_ack_d;
         ticket_q    <= ticket_d;
         line_addr_q <= line_addr_d;
         awaddr_q    <= awaddr_d;
         aw_pend_q   <= aw_pend_d;
         res_q       <= res_d;
         cap_cnt_q   <= cap_cnt_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         w_cnt_q     <= w_cnt_d;
         oc_q        <= oc_d;
         wvalid_q    <= wvalid_d;
         wlast_q     <= wlast_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         busy_q      <= busy_d;
      end
   end

   // FIFO storage; contents are don't-care while the count says empty.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign bus.wb_ack            = wb_ack_q;
   assign bus.ticket_rqst_rd    = ticket_q;
   assign bus.rd_fifo_rqst_addr = line_addr_q;
   assign bus.awaddr            = awaddr_q;
   assign bus.awlen             = 8'(BEATS - 1);
   assign bus.awvalid           = aw_pend_q;
   assign bus.wdata             = wdata_q;
   assign bus.wstrb             = wstrb_q;
   assign bus.wlast             = wlast_q;
   assign bus.wvalid            = wvalid_q;
   assign bus.bready            = 1'b1;
   assign bus.busy              = busy_q;
endmodule
